glitch_filter_mc: RTL and testbench

//  Multi-channel, bidirectional glitch/debounce filter for asynchronous inputs at the clk boundary.

---
 rtl/glitch_filter_mc_if.sv | 26 ++
 rtl/glitch_filter_mc.sv | 147 ++++++++++++++
 tb/tb_glitch_filter_mc.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_filter_mc_if.sv
// Pin-side bundle for glitch_filter_mc: raw inputs, filtered levels,
// edge strobes and glitch diagnostics.
interface glitch_filter_mc_if #(
   parameter int NUM_CH = 4,
   parameter int GCNT_W = 8
);
   logic [NUM_CH-1:0]        signal_in;
   logic                     glitch_clr;
   logic [NUM_CH-1:0]        o_signal;
   logic [NUM_CH-1:0]        rise_pulse;
   logic [NUM_CH-1:0]        fall_pulse;
   logic [NUM_CH-1:0]        glitch_flag;
   logic [NUM_CH*GCNT_W-1:0] glitch_cnt;

   modport master (
      output signal_in, glitch_clr,
      input  o_signal, rise_pulse, fall_pulse,
      input  glitch_flag, glitch_cnt
   );

   modport slave (
      input  signal_in, glitch_clr,
      output o_signal, rise_pulse, fall_pulse,
      output glitch_flag, glitch_cnt
   );
endinterface

// File: rtl/glitch_filter_mc.sv
// Multi-channel synchronising glitch/debounce filter with per-channel
// edge strobes and saturating glitch counters.
module glitch_filter_mc #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_HIGH    = 100,
   parameter int MIN_LOW     = 100,
   parameter int FILT_MODE   = 2,
   parameter int INIT_LEVEL  = 0,
   parameter int GCNT_W      = 8
) (
   input  logic           clk,
   input  logic           rst,
   glitch_filter_mc_if.slave bus
);

   localparam int TH_HI  = (FILT_MODE != 1) ? MIN_HIGH : 1;
   localparam int TH_LO  = (FILT_MODE != 0) ? MIN_LOW : 1;
   localparam int MAX_TH = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
   localparam int CW     = $clog2(MAX_TH) + 1;
   localparam logic INIT_B = 1'(INIT_LEVEL);

   typedef enum logic [1:0] {
      ST_LO,
      PEND_HI,
      ST_HI,
      PEND_LO
   } st_t;

   logic [NUM_CH-1:0]        o_v;
   logic [NUM_CH-1:0]        rp_v;
   logic [NUM_CH-1:0]        fp_v;
   logic [NUM_CH-1:0]        gf_v;
   logic [NUM_CH*GCNT_W-1:0] gc_v;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      st_t                    st;
      logic [CW-1:0]          cnt;
      logic                   o_q;
      logic                   o_d;
      logic                   rp;
      logic                   fp;
      logic                   gf;
      logic [GCNT_W-1:0]      gc;
      logic                   s;
      logic                   glitch;

      assign s      = sync[SYNC_STAGES-1];
      assign glitch = ((st == PEND_HI) && !s) ||
                      ((st == PEND_LO) && s);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync <= {SYNC_STAGES{INIT_B}};
            st   <= INIT_B ? ST_HI : ST_LO;
            cnt  <= '0;
            o_q  <= INIT_B;
            o_d  <= INIT_B;
            rp   <= 1'b0;
            fp   <= 1'b0;
            gf   <= 1'b0;
            gc   <= '0;
         end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.signal_in[i]};
            // strobes trail the level change by one cycle
            o_d  <= o_q;
            rp   <= o_q & ~o_d;
            fp   <= ~o_q & o_d;
            unique case (st)
               ST_LO: begin
                  if (s) begin
                     if (TH_HI == 1) begin
                        st  <= ST_HI;
                        o_q <= 1'b1;
                     end else begin
                        st  <= PEND_HI;
                        cnt <= CW'(1);
                     end
                  end
               end
               PEND_HI: begin
                  if (!s) begin
                     st  <= ST_LO;
                     cnt <= '0;
                  end else if (cnt == CW'(TH_HI - 1)) begin
                     st  <= ST_HI;
                     cnt <= '0;
                     o_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_HI: begin
                  if (!s) begin
                     if (TH_LO == 1) begin
                        st  <= ST_LO;
                        o_q <= 1'b0;
                     end else begin
                        st  <= PEND_LO;
                        cnt <= CW'(1);
                     end
                  end
               end
               PEND_LO: begin
                  if (s) begin
                     st  <= ST_HI;
                     cnt <= '0;
                  end else if (cnt == CW'(TH_LO - 1)) begin
                     st  <= ST_LO;
                     cnt <= '0;
                     o_q <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  st  <= ST_LO;
                  cnt <= '0;
               end
            endcase
            // a coincident glitch outranks the clear
            if (glitch) begin
               gf <= 1'b1;
               if (bus.glitch_clr) gc <= GCNT_W'(1);
               else if (!(&gc))    gc <= gc + 1'b1;
            end else if (bus.glitch_clr) begin
               gf <= 1'b0;
               gc <= '0;
            end
         end
      end

      assign o_v[i]                   = o_q;
      assign rp_v[i]                  = rp;
      assign fp_v[i]                  = fp;
      assign gf_v[i]                  = gf;
      assign gc_v[i*GCNT_W +: GCNT_W] = gc;
   end

   assign bus.o_signal    = o_v;
   assign bus.rise_pulse  = rp_v;
   assign bus.fall_pulse  = fp_v;
   assign bus.glitch_flag = gf_v;
   assign bus.glitch_cnt  = gc_v;

endmodule

// File: tb/tb_glitch_filter_mc.sv
// Bench for glitch_filter_mc: four configurations checked each cycle
// against a run-length model, plus hand-computed directed checks.
module tb_glitch_filter_mc;

   logic clk;
   logic rst;
   logic [3:0] sin [4];
   logic       clr [4];

   logic [3:0] d_o [4];
   logic [3:0] d_r [4];
   logic [3:0] d_f [4];
   logic [3:0] d_g [4];
   logic [7:0] d_c [4][4];

   int n_err = 0;
   int n_chk = 0;
   bit chk_en = 0;

   glitch_filter_mc_if #(.NUM_CH(4), .GCNT_W(8)) if0 ();
   glitch_filter_mc_if #(.NUM_CH(4), .GCNT_W(8)) if1 ();
   glitch_filter_mc_if #(.NUM_CH(4), .GCNT_W(2)) if2 ();
   glitch_filter_mc_if #(.NUM_CH(4), .GCNT_W(8)) if3 ();

   glitch_filter_mc u0 (.clk(clk), .rst(rst), .bus(if0));
   glitch_filter_mc #(.FILT_MODE(0)) u1 (
      .clk(clk), .rst(rst), .bus(if1));
   glitch_filter_mc #(.GCNT_W(2)) u2 (
      .clk(clk), .rst(rst), .bus(if2));
   glitch_filter_mc #(.INIT_LEVEL(1)) u3 (
      .clk(clk), .rst(rst), .bus(if3));

   assign if0.signal_in = sin[0];
   assign if1.signal_in = sin[1];
   assign if2.signal_in = sin[2];
   assign if3.signal_in = sin[3];
   assign if0.glitch_clr = clr[0];
   assign if1.glitch_clr = clr[1];
   assign if2.glitch_clr = clr[2];
   assign if3.glitch_clr = clr[3];

   assign d_o[0] = if0.o_signal;
   assign d_o[1] = if1.o_signal;
   assign d_o[2] = if2.o_signal;
   assign d_o[3] = if3.o_signal;
   assign d_r[0] = if0.rise_pulse;
   assign d_r[1] = if1.rise_pulse;
   assign d_r[2] = if2.rise_pulse;
   assign d_r[3] = if3.rise_pulse;
   assign d_f[0] = if0.fall_pulse;
   assign d_f[1] = if1.fall_pulse;
   assign d_f[2] = if2.fall_pulse;
   assign d_f[3] = if3.fall_pulse;
   assign d_g[0] = if0.glitch_flag;
   assign d_g[1] = if1.glitch_flag;
   assign d_g[2] = if2.glitch_flag;
   assign d_g[3] = if3.glitch_flag;

   for (genvar k = 0; k < 4; k++) begin : g_cnt
      assign d_c[0][k] = if0.glitch_cnt[k*8 +: 8];
      assign d_c[1][k] = if1.glitch_cnt[k*8 +: 8];
      assign d_c[2][k] = {6'd0, if2.glitch_cnt[k*2 +: 2]};
      assign d_c[3][k] = if3.glitch_cnt[k*8 +: 8];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // per-instance configuration as seen from the pins
   int th_hi [4] = '{100, 100, 100, 100};
   int th_lo [4] = '{100, 1, 100, 100};
   int init  [4] = '{0, 0, 0, 1};
   int gmax  [4] = '{255, 255, 3, 255};

   // model: level, length of the current run away from it, counters
   int m_lvl [4][4];
   int m_run [4][4];
   int m_gc  [4][4];
   bit m_gf  [4][4];
   bit m_pr  [4][4];
   bit m_pf  [4][4];
   bit m_er  [4][4];
   bit m_ef  [4][4];
   int m_dl  [4][4][$];

   task automatic m_reset();
      for (int n = 0; n < 4; n++)
         for (int c = 0; c < 4; c++) begin
            m_lvl[n][c] = init[n];
            m_run[n][c] = 0;
            m_gc[n][c]  = 0;
            m_gf[n][c]  = 0;
            m_pr[n][c]  = 0;
            m_pf[n][c]  = 0;
            m_er[n][c]  = 0;
            m_ef[n][c]  = 0;
            m_dl[n][c]  = {init[n], init[n]};
         end
   endtask

   task automatic m_edge();
      int v;
      int th;
      bit g;
      for (int n = 0; n < 4; n++)
         for (int c = 0; c < 4; c++) begin
            v = m_dl[n][c].pop_front();
            m_dl[n][c].push_back(int'(sin[n][c]));
            m_pr[n][c] = m_er[n][c];
            m_pf[n][c] = m_ef[n][c];
            m_er[n][c] = 0;
            m_ef[n][c] = 0;
            g = 0;
            th = (m_lvl[n][c] != 0) ? th_lo[n] : th_hi[n];
            if (v != m_lvl[n][c]) begin
               m_run[n][c]++;
               if (m_run[n][c] == th) begin
                  m_lvl[n][c] = v;
                  m_run[n][c] = 0;
                  if (v != 0) m_er[n][c] = 1;
                  else        m_ef[n][c] = 1;
               end
            end else if (m_run[n][c] > 0) begin
               g = 1;
               m_run[n][c] = 0;
            end
            if (g) begin
               m_gf[n][c] = 1;
               if (clr[n]) m_gc[n][c] = 1;
               else if (m_gc[n][c] < gmax[n]) m_gc[n][c]++;
            end else if (clr[n]) begin
               m_gf[n][c] = 0;
               m_gc[n][c] = 0;
            end
         end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) m_reset();
         else      m_edge();
      end
   end

   task automatic chk(input string nm, input int n,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s u%0d @%0t: got %0h expected %0h",
                     nm, n, $time, act, exp);
      end
   endtask

   initial begin
      logic [3:0] eo, er, ef, eg;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int n = 0; n < 4; n++) begin
               for (int c = 0; c < 4; c++) begin
                  eo[c] = m_lvl[n][c] != 0;
                  er[c] = m_pr[n][c];
                  ef[c] = m_pf[n][c];
                  eg[c] = m_gf[n][c];
                  chk("model glitch_cnt", n*4 + c,
                      32'(d_c[n][c]), 32'(m_gc[n][c]));
               end
               chk("model o_signal", n, 32'(d_o[n]), 32'(eo));
               chk("model rise_pulse", n, 32'(d_r[n]), 32'(er));
               chk("model fall_pulse", n, 32'(d_f[n]), 32'(ef));
               chk("model glitch_flag", n, 32'(d_g[n]), 32'(eg));
            end
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   int rem [4][4];

   initial begin
      for (int n = 0; n < 4; n++) begin
         sin[n] = 4'h0;
         clr[n] = 1'b0;
      end
      sin[3] = 4'hf;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("reset o_signal", 0, 32'(d_o[0]), 32'h0);
      chk("reset o_signal", 3, 32'(d_o[3]), 32'hf);
      chk("reset rise", 0, 32'(d_r[0]), 32'h0);
      chk("reset fall", 3, 32'(d_f[3]), 32'h0);
      chk("reset flag", 2, 32'(d_g[2]), 32'h0);
      chk("reset cnt", 1, 32'(d_c[1][0]), 32'h0);
      tick(3);
      rst = 1'b1;
      chk_en = 1;

      // ch0 high 99 cycles (rejected), ch1 high 100+ cycles (accepted)
      sin[0] = 4'b0011;
      tick(99);
      sin[0][0] = 1'b0;
      tick(2);
      chk("t2 o before", 0, 32'(d_o[0][1]), 32'h0);
      tick(1);
      chk("t2 o rise", 0, 32'(d_o[0][1]), 32'h1);
      chk("t2 rise early", 0, 32'(d_r[0][1]), 32'h0);
      tick(1);
      chk("t2 rise pulse", 0, 32'(d_r[0][1]), 32'h1);
      tick(1);
      chk("t2 rise width", 0, 32'(d_r[0][1]), 32'h0);
      chk("t1 o stays", 0, 32'(d_o[0][0]), 32'h0);
      chk("t1 cnt", 0, 32'(d_c[0][0]), 32'h1);
      chk("t1 flag", 0, 32'(d_g[0][0]), 32'h1);
      chk("t2 cnt", 0, 32'(d_c[0][1]), 32'h0);

      // high-only filtering: a 3-cycle low dip passes through
      sin[1][0] = 1'b1;
      tick(110);
      chk("t3 o high", 1, 32'(d_o[1][0]), 32'h1);
      sin[1][0] = 1'b0;
      tick(2);
      chk("t3 o before", 1, 32'(d_o[1][0]), 32'h1);
      tick(1);
      chk("t3 o fall", 1, 32'(d_o[1][0]), 32'h0);
      sin[1][0] = 1'b1;
      tick(1);
      chk("t3 fall pulse", 1, 32'(d_f[1][0]), 32'h1);
      tick(120);
      chk("t3 o back", 1, 32'(d_o[1][0]), 32'h1);
      chk("t3 cnt", 1, 32'(d_c[1][0]), 32'h0);
      chk("t3 flag", 1, 32'(d_g[1][0]), 32'h0);

      // 2-bit counter saturation, then clear racing a glitch
      repeat (5) begin
         sin[2][2] = 1'b1;
         tick(10);
         sin[2][2] = 1'b0;
         tick(10);
      end
      chk("t4 sat cnt", 2, 32'(d_c[2][2]), 32'h3);
      chk("t4 flag", 2, 32'(d_g[2][2]), 32'h1);
      sin[2][2] = 1'b1;
      tick(10);
      sin[2][2] = 1'b0;
      tick(2);
      clr[2] = 1'b1;
      tick(1);
      clr[2] = 1'b0;
      chk("t4 clr+glitch cnt", 2, 32'(d_c[2][2]), 32'h1);
      chk("t4 clr+glitch flag", 2, 32'(d_g[2][2]), 32'h1);
      clr[2] = 1'b1;
      tick(1);
      clr[2] = 1'b0;
      chk("t4 clr cnt", 2, 32'(d_c[2][2]), 32'h0);
      chk("t4 clr flag", 2, 32'(d_g[2][2]), 32'h0);

      // asynchronous reset in the middle of a pending rise
      sin[0][2] = 1'b1;
      tick(52);
      #2 rst = 1'b0;
      #1;
      chk("t5 async o", 0, 32'(d_o[0]), 32'h0);
      chk("t5 async cnt", 0, 32'(d_c[0][0]), 32'h0);
      chk("t5 async flag", 0, 32'(d_g[0]), 32'h0);
      chk("t5 async o init1", 3, 32'(d_o[3]), 32'hf);
      tick(2);
      rst = 1'b1;
      tick(101);
      chk("t5 o before", 0, 32'(d_o[0][2]), 32'h0);
      tick(1);
      chk("t5 o rise", 0, 32'(d_o[0][2]), 32'h1);

      // random pulses on every channel of every configuration
      for (int n = 0; n < 4; n++)
         for (int c = 0; c < 4; c++) rem[n][c] = 1;
      repeat (4000) begin
         for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 4; c++) begin
               rem[n][c]--;
               if (rem[n][c] == 0) begin
                  sin[n][c] = ~sin[n][c];
                  if ($urandom_range(0, 3) == 0)
                     rem[n][c] = int'($urandom_range(98, 102));
                  else
                     rem[n][c] = int'($urandom_range(1, 200));
               end
            end
            clr[n] = ($urandom_range(0, 63) == 0);
         end
         tick(1);
      end
      for (int n = 0; n < 4; n++) clr[n] = 1'b0;
      tick(2);
      chk_en = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
